// File: rtl/run_ctrl_if.sv
// run_ctrl_if: host load stream, RAM write port, CPU control/debug and dump stream of the run controller.
// master is the controller side, slave is the machine/host side.
interface run_ctrl_if #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int CYC_W    = 32
);
  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic              start;
  logic [ADDR_W:0]   load_len;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_reset;
  logic              cpu_clk_en;
  logic              cpu_halted;
  logic [SEL_W-1:0]  reg_sel;
  logic [DATA_W-1:0] reg_rdata;
  logic              dump_valid;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;
  logic              dump_ready;
  logic              busy;
  logic              timed_out;
  logic [CYC_W-1:0]  cycle_count;

  modport master (
    input  start, load_len, load_valid, load_data, cpu_halted, reg_rdata, dump_ready,
    output load_ready, mem_we, mem_addr, mem_wdata, cpu_reset, cpu_clk_en, reg_sel,
           dump_valid, dump_data, dump_last, busy, timed_out, cycle_count
  );

  modport slave (
    output start, load_len, load_valid, load_data, cpu_halted, reg_rdata, dump_ready,
    input  load_ready, mem_we, mem_addr, mem_wdata, cpu_reset, cpu_clk_en, reg_sel,
           dump_valid, dump_data, dump_last, busy, timed_out, cycle_count
  );
endinterface

// File: rtl/run_ctrl.sv
// run_ctrl: loads a program image, pulses CPU reset, runs the CPU under a watchdog, then dumps the registers.
// Optional macro RUN_CTRL_CYCLE_COUNT_EN appends the run cycle count (LSB word first) to the dump.
module run_ctrl #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int NUM_REGS   = 8,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 10000,
  parameter int CYC_W      = 32
) (
  input logic        clk,
  input logic        reset,
  run_ctrl_if.master bus
);
  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
`ifdef RUN_CTRL_CYCLE_COUNT_EN
  localparam int CNT_WORDS = (CYC_W + DATA_W - 1) / DATA_W;
`else
  localparam int CNT_WORDS = 0;
`endif
  localparam int DUMP_WORDS = NUM_REGS + CNT_WORDS;
  localparam int K_W        = $clog2(DUMP_WORDS + 1);
  localparam int RC_W       = $clog2(RST_CYCLES + 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] CRST = 3'd2;
  localparam logic [2:0] RUN  = 3'd3;
  localparam logic [2:0] DUMP = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam logic [RC_W-1:0]  RST_LAST  = RC_W'(RST_CYCLES - 1);
  localparam logic [K_W-1:0]   K_REGS    = K_W'(NUM_REGS);
  localparam logic [K_W-1:0]   K_LAST    = K_W'(DUMP_WORDS - 1);
  localparam logic [CYC_W-1:0] TIMEOUT_C = CYC_W'(TIMEOUT);

  logic [2:0]        state;
  logic [ADDR_W:0]   load_len_q;
  logic [ADDR_W:0]   load_cnt;
  logic [RC_W-1:0]   rst_cnt;
  logic [K_W-1:0]    dump_k;
  logic              cap_pending;
  logic              load_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [SEL_W-1:0]  reg_sel_q;
  logic              dump_valid_q;
  logic              dump_last_q;
  logic [DATA_W-1:0] dump_data_q;
  logic [DATA_W-1:0] dump_src;
  logic              timed_out_q;
  logic [CYC_W-1:0]  cycle_count_q;
  logic              expired;
  logic              run_en;

  // The clock gate drops combinationally on halt or expiry so the CPU never advances past that cycle.
  assign expired = (cycle_count_q >= TIMEOUT_C);
  assign run_en  = (state == RUN) && !bus.cpu_halted && !expired;

`ifdef RUN_CTRL_CYCLE_COUNT_EN
  logic [CNT_WORDS*DATA_W-1:0] cnt_pad;
  assign cnt_pad = (CNT_WORDS*DATA_W)'(cycle_count_q);
`endif

  always_comb begin
    dump_src = bus.reg_rdata;
`ifdef RUN_CTRL_CYCLE_COUNT_EN
    if (dump_k >= K_REGS)
      dump_src = DATA_W'(cnt_pad >> ((int'(dump_k) - NUM_REGS) * DATA_W));
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      load_len_q    <= '0;
      load_cnt      <= '0;
      rst_cnt       <= '0;
      dump_k        <= '0;
      cap_pending   <= 1'b0;
      load_ready_q  <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      reg_sel_q     <= '0;
      dump_valid_q  <= 1'b0;
      dump_last_q   <= 1'b0;
      dump_data_q   <= '0;
      timed_out_q   <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            load_len_q    <= bus.load_len;
            load_cnt      <= '0;
            rst_cnt       <= '0;
            cycle_count_q <= '0;
            timed_out_q   <= 1'b0;
            if (bus.load_len != '0) begin
              load_ready_q <= 1'b1;
              state        <= LOAD;
            end else begin
              state <= CRST;
            end
          end
        end
        LOAD: begin
          if (bus.load_valid && load_ready_q) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= load_cnt[ADDR_W-1:0];
            mem_wdata_q <= bus.load_data;
            load_cnt    <= load_cnt + (ADDR_W+1)'(1);
            if (load_cnt + (ADDR_W+1)'(1) == load_len_q) begin
              load_ready_q <= 1'b0;
              state        <= CRST;
            end
          end
        end
        CRST: begin
          if (rst_cnt == RST_LAST)
            state <= RUN;
          else
            rst_cnt <= rst_cnt + RC_W'(1);
        end
        RUN: begin
          dump_k      <= '0;
          cap_pending <= 1'b0;
          if (bus.cpu_halted) begin
            state <= DUMP;
          end else if (expired) begin
            timed_out_q <= 1'b1;
            state       <= DUMP;
          end else if (cycle_count_q != '1) begin
            cycle_count_q <= cycle_count_q + CYC_W'(1);
          end
        end
        // Each word: select register, capture one cycle later, then hold until accepted.
        DUMP: begin
          if (dump_valid_q) begin
            if (bus.dump_ready) begin
              dump_valid_q <= 1'b0;
              dump_last_q  <= 1'b0;
              if (dump_last_q)
                state <= DONE;
              else
                dump_k <= dump_k + K_W'(1);
            end
          end else if (cap_pending) begin
            dump_data_q  <= dump_src;
            dump_valid_q <= 1'b1;
            dump_last_q  <= (dump_k == K_LAST);
            cap_pending  <= 1'b0;
          end else begin
            if (dump_k < K_REGS)
              reg_sel_q <= dump_k[SEL_W-1:0];
            cap_pending <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.load_ready  = load_ready_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.cpu_reset   = (state == IDLE) || (state == LOAD) || (state == CRST);
  assign bus.cpu_clk_en  = run_en;
  assign bus.reg_sel     = reg_sel_q;
  assign bus.dump_valid  = dump_valid_q;
  assign bus.dump_data   = dump_data_q;
  assign bus.dump_last   = dump_last_q;
  assign bus.busy        = (state != IDLE);
  assign bus.timed_out   = timed_out_q;
  assign bus.cycle_count = cycle_count_q;
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed sessions covering load, CPU reset pulse, halt and watchdog runs, dump back-pressure and abort.
// Define RUN_CTRL_CYCLE_COUNT_EN to also cover the appended cycle count words.
module tb_run_ctrl;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 8;
  localparam int NUM_REGS   = 8;
  localparam int RST_CYCLES = 2;
  localparam int CYC_W      = 32;
`ifdef RUN_CTRL_CYCLE_COUNT_EN
  localparam int TO_TB     = 400;
  localparam int CNT_WORDS = 4;
`else
  localparam int TO_TB     = 100;
  localparam int CNT_WORDS = 0;
`endif
  localparam int DUMP_WORDS = NUM_REGS + CNT_WORDS;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   assertCount = 0;
  int   failCount   = 0;
  int   wrN = 0;
  logic [7:0] wrAddr [16];
  logic [7:0] wrData [16];
  logic [7:0] loadBytes [3];
  int   crst;
  int   lat;
  int   hi;

  run_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .CYC_W(CYC_W)) bus();

  run_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
    .RST_CYCLES(RST_CYCLES), .TIMEOUT(TO_TB), .CYC_W(CYC_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Register file model of the machine: register k reads as 0x10+k.
  always_comb bus.reg_rdata = 8'h10 + 8'(bus.reg_sel);

  always @(negedge clk) begin
    if (bus.mem_we && wrN < 16) begin
      wrAddr[wrN] <= bus.mem_addr;
      wrData[wrN] <= bus.mem_wdata;
      wrN         <= wrN + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] expectedWord(input int k, input logic [31:0] count);
    if (k < NUM_REGS) return 8'h10 + 8'(k);
    return 8'(count >> (8 * (k - NUM_REGS)));
  endfunction

  task automatic applyStimulus(input logic [8:0] len);
    bus.start    = 1'b1;
    bus.load_len = len;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] data, input int gap);
    int guard = 0;
    while (!bus.load_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) checkOutput("load_ready_timeout", bus.load_ready, 1'b1);
    bus.load_valid = 1'b1;
    bus.load_data  = data;
    @(negedge clk);
    bus.load_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic waitRun(output int crstCycles);
    int guard = 0;
    crstCycles = 0;
    while (!bus.cpu_clk_en && guard < 50) begin
      if (bus.cpu_reset) crstCycles++;
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("run_start_timeout", bus.cpu_clk_en, 1'b1);
  endtask

  task automatic waitDumpValid(output int latency);
    latency = 0;
    while (!bus.dump_valid && latency < 50) begin
      @(negedge clk);
      latency++;
    end
  endtask

  task automatic collectDump(input int stallWord, input int stallCycles, input logic [31:0] expCount);
    int   got = 0;
    int   guard = 0;
    int   stall = stallCycles;
    int   clkEnHigh = 0;
    logic stalling = 1'b0;
    logic [7:0] expData;
    while (got < DUMP_WORDS && guard < 2000) begin
      bus.dump_ready = 1'b0;
      if (bus.cpu_clk_en) clkEnHigh++;
      if (stalling) checkOutput("dump_hold_valid", bus.dump_valid, 1'b1);
      if (bus.dump_valid) begin
        expData = expectedWord(got, expCount);
        if (got == stallWord && stall > 0) begin
          stalling = 1'b1;
          checkOutput("dump_hold_data", bus.dump_data, expData);
          stall--;
        end else begin
          stalling = 1'b0;
          checkOutput($sformatf("dump_word%0d", got), bus.dump_data, expData);
          checkOutput($sformatf("dump_last%0d", got), bus.dump_last, (got == DUMP_WORDS - 1));
          bus.dump_ready = 1'b1;
          got++;
        end
      end
      @(negedge clk);
      guard++;
    end
    bus.dump_ready = 1'b0;
    checkOutput("dump_word_count", got, DUMP_WORDS);
    checkOutput("dump_clk_en_low", clkEnHigh, 0);
  endtask

  task automatic finishSession();
    checkOutput("done_busy", bus.busy, 1'b1);
    checkOutput("done_cpu_reset", bus.cpu_reset, 1'b0);
    @(negedge clk);
    checkOutput("idle_busy", bus.busy, 1'b0);
    checkOutput("idle_cpu_reset", bus.cpu_reset, 1'b1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ctrl"},
      {bus.load_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_reset, bus.cpu_clk_en,
       bus.reg_sel, bus.dump_valid, bus.dump_data, bus.dump_last, bus.busy, bus.timed_out},
      {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    checkOutput({tag, "_count"}, bus.cycle_count, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    loadBytes[0] = 8'hA1;
    loadBytes[1] = 8'hB2;
    loadBytes[2] = 8'hC3;
    bus.start      = 1'b0;
    bus.load_len   = '0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.cpu_halted = 1'b0;
    bus.dump_ready = 1'b0;

    @(negedge clk);
    checkResetState("reset_state");
    reset = 1'b1;
    @(negedge clk);

    // Session A: three bytes with gaps, halt after 50 run cycles, start pulse ignored, stalled dump word.
    applyStimulus(9'd3);
    for (int i = 0; i < 3; i++) sendByte(loadBytes[i], 2 - i);
    checkOutput("load_ready_drop", bus.load_ready, 1'b0);
    waitRun(crst);
    checkOutput("crst_cycles", crst, RST_CYCLES);
    checkOutput("run_cpu_reset", bus.cpu_reset, 1'b0);
    checkOutput("write_count", wrN, 3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("write_addr%0d", i), wrAddr[i], i);
      checkOutput($sformatf("write_data%0d", i), wrData[i], loadBytes[i]);
    end
    for (int i = 0; i < 50; i++) begin
      bus.start = (i == 20);
      @(negedge clk);
    end
    bus.start      = 1'b0;
    bus.cpu_halted = 1'b1;
    #1 checkOutput("halt_clk_en_drop", bus.cpu_clk_en, 1'b0);
    waitDumpValid(lat);
    checkOutput("halt_dump_latency", lat, 3);
    collectDump(3, 5, 32'd50);
    finishSession();
    checkOutput("halt_timed_out", bus.timed_out, 1'b0);
    checkOutput("halt_cycle_count", bus.cycle_count, 50);
    bus.cpu_halted = 1'b0;
    @(negedge clk);

    // Session B: no load, CPU never halts, watchdog ends the run.
    applyStimulus(9'd0);
    waitRun(crst);
    checkOutput("to_crst_cycles", crst, RST_CYCLES);
    hi = 0;
    while (bus.cpu_clk_en && hi < 20000) begin
      hi++;
      @(negedge clk);
    end
    checkOutput("to_enabled_cycles", hi, TO_TB);
    waitDumpValid(lat);
    checkOutput("to_dump_latency", lat, 3);
    collectDump(-1, 0, 32'(TO_TB));
    finishSession();
    checkOutput("to_timed_out", bus.timed_out, 1'b1);
    checkOutput("to_cycle_count", bus.cycle_count, TO_TB);

    // Session C: abort during load, then a load-less session halting at once.
    applyStimulus(9'd4);
    checkOutput("start_clears_timed_out", bus.timed_out, 1'b0);
    checkOutput("start_clears_count", bus.cycle_count, 0);
    sendByte(8'h55, 0);
    checkOutput("abort_write_seen", bus.mem_we, 1'b1);
    reset = 1'b0;
    #1 checkResetState("abort");
    @(negedge clk);
    checkResetState("abort_held");
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(9'd0);
    checkOutput("skip_load_ready", bus.load_ready, 1'b0);
    checkOutput("skip_load_busy", bus.busy, 1'b1);
    waitRun(crst);
    checkOutput("skip_crst_cycles", crst, RST_CYCLES);
    bus.cpu_halted = 1'b1;
    waitDumpValid(lat);
    collectDump(-1, 0, 32'd0);
    finishSession();
    checkOutput("skip_cycle_count", bus.cycle_count, 0);
    bus.cpu_halted = 1'b0;
    @(negedge clk);

`ifdef RUN_CTRL_CYCLE_COUNT_EN
    // Session D: halt after 300 run cycles, count words 0x2C,0x01,0x00,0x00 follow the registers.
    applyStimulus(9'd0);
    waitRun(crst);
    repeat (300) @(negedge clk);
    bus.cpu_halted = 1'b1;
    waitDumpValid(lat);
    collectDump(-1, 0, 32'd300);
    finishSession();
    checkOutput("count_cycle_count", bus.cycle_count, 300);
    bus.cpu_halted = 1'b0;
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Synthesizable run controller for the 8-bit machine. It replaces the bench-only load, reset, run, timeout and halt-report sequence with hardware.
- Loads a program image into RAM from a byte stream, then pulses CPU reset, then gates the CPU clock with a watchdog running.
- On halt or timeout it freezes the CPU and streams out a snapshot of the register file.
- Sits between a host link (UART or JTAG bridge) and the machine's RAM write port, CPU reset, clock enable and register debug read port.

Parameters:
DATA_W, 8, RAM and register data width
ADDR_W, 8, RAM address width
NUM_REGS, 8, registers dumped (A..G, Temp), index 0..NUM_REGS-1
RST_CYCLES, 2, cycles cpu_reset is held high before run (min 1)
TIMEOUT, 10000, run cycles before watchdog fires (min 2)
CYC_W, 32, cycle counter width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse, begins a session (honoured in IDLE only)
load_len  input  ADDR_W+1  bytes to load, sampled on start; 0 = skip load
load_valid  input  1  load byte valid
load_data  input  DATA_W  load byte
load_ready  output  1  accepting load bytes
mem_we  output  1  RAM write strobe
mem_addr  output  ADDR_W  RAM write address
mem_wdata  output  DATA_W  RAM write data
cpu_reset  output  1  active-high CPU reset
cpu_clk_en  output  1  CPU clock enable
cpu_halted  input  1  CPU halted flag (level)
reg_sel  output  $clog2(NUM_REGS)  register debug read select
reg_rdata  input  DATA_W  combinational register read data
dump_valid  output  1  dump word valid
dump_data  output  DATA_W  dump word
dump_last  output  1  final dump word
dump_ready  input  1  dump consumer ready
busy  output  1  state != IDLE
timed_out  output  1  last session ended by watchdog; sticky until next start
cycle_count  output  CYC_W  run cycles of current/last session

Behaviour:
- Reset (reset=0, async): state IDLE, cpu_reset=1, cpu_clk_en=0, mem_we=0, load_ready=0, dump_valid=0, dump_last=0, reg_sel=0, busy=0, timed_out=0, cycle_count=0, mem_addr=0, mem_wdata=0, dump_data=0.
  - Reset mid-session aborts immediately; no partial dump is emitted.
- States: IDLE, LOAD, CRST, RUN, DUMP, DONE.
- IDLE:
  - start=1: latch load_len, clear cycle_count and timed_out, address counter=0.
  - Go to LOAD if load_len!=0, else CRST.
- LOAD:
  - load_ready=1.
  - Each load_valid&load_ready handshake produces, in the next cycle, mem_we=1, mem_addr=counter, mem_wdata=byte; counter then increments.
  - After load_len handshakes: load_ready drops in the cycle after the last accept; go to CRST.
  - load_len=2^ADDR_W fills RAM fully; the address wraps to 0 and is not reused.
- CRST: cpu_reset=1, cpu_clk_en=0 for exactly RST_CYCLES cycles, then RUN.
- RUN:
  - cpu_reset=0, cpu_clk_en=1, cycle_count increments every cycle, saturating at all-ones.
  - cpu_halted=1 → DUMP, with cpu_clk_en deasserted in that same transition cycle.
  - cycle_count reaching TIMEOUT with cpu_halted=0 → timed_out=1, then DUMP.
  - Halt and timeout in the same cycle: halt wins, timed_out stays 0.
- DUMP:
  - cpu_clk_en=0, cpu_reset=0 (registers preserved).
  - For k=0..NUM_REGS-1: drive reg_sel=k, capture reg_rdata into dump_data one cycle later, assert dump_valid.
  - dump_data and dump_last hold stable while dump_valid=1 and dump_ready=0.
  - A handshake advances k. First dump_valid occurs 2 cycles after DUMP entry.
  - dump_last=1 on the final word. After its handshake go to DONE.
- DONE: one cycle, then IDLE. cpu_reset returns to 1 on entering IDLE. cycle_count and timed_out hold.
- start outside IDLE is ignored. load_valid outside LOAD is ignored (load_ready=0).

Optional Feature:
RUN_CTRL_CYCLE_COUNT_EN
- Defined: after the registers, DUMP appends ceil(CYC_W/DATA_W) words of cycle_count, LSB word first. dump_last moves to the final count word.
- Not defined: the dump is exactly NUM_REGS words. cycle_count is used only by the watchdog and the cycle_count port.

Test Plan:
- load_len=3, bytes 0xA1,0xB2,0xC3 with gaps on load_valid → mem_we writes addr 0,1,2 with those bytes; then cpu_reset high for exactly 2 cycles; then cpu_clk_en=1.
- Run, raise cpu_halted after 50 RUN cycles, reg_rdata=0x10+reg_sel → 8 dump words 0x10..0x17, dump_last on 0x17, timed_out=0, cycle_count=50.
- cpu_halted never rises, TIMEOUT=100 → timed_out=1, cycle_count=100, dump of 8 words, cpu_clk_en=0 from the expiry cycle onward.
- dump_ready held low 5 cycles on word 3 → dump_data stable at 0x13, dump_valid held; start pulse mid-run ignored.
- reset=0 during LOAD after 1 byte → all outputs at reset values immediately; a new start with load_len=0 goes straight to CRST.
- With RUN_CTRL_CYCLE_COUNT_EN and a halt after 300 cycles → dump 0x10..0x17, then 0x2C,0x01,0x00,0x00, dump_last on the final 0x00.
